// File: rtl/chu_gpi_pkg.sv
// Shared constants for the debounced GPI slot core: register map, prescaler
// width and the per-channel debounce counter sizing.
package chu_gpi_pkg;

    localparam logic [4:0] REG_SYNC  = 5'd0;
    localparam logic [4:0] REG_DEB   = 5'd1;
    localparam logic [4:0] REG_RISE  = 5'd2;
    localparam logic [4:0] REG_FALL  = 5'd3;
    localparam logic [4:0] REG_MASK  = 5'd4;
    localparam logic [4:0] REG_PRESC = 5'd5;

    localparam int PRESC_W = 16;

    // Counter only has to hold 0..samples-1; keep at least one bit.
    function automatic int cnt_width(input int samples);
        return (samples <= 2) ? 1 : $clog2(samples);
    endfunction

endpackage

// File: rtl/chu_debounce_ch.sv
// One debounce channel: accepts a new level after DB_SAMPLES consecutive
// differing ticks and pulses rise/fall in the cycle the level is accepted.
module chu_debounce_ch
    import chu_gpi_pkg::*;
#(
    parameter int DB_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sync,
    input  logic tick,
    output logic deb,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CNT_W = cnt_width(DB_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_SAMPLES - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             deb_reg, deb_next;
    logic             accept;

    always_comb begin
        cnt_next = cnt_reg;
        deb_next = deb_reg;
        accept   = tick && (sync != deb_reg) && (cnt_reg == CNT_LAST);
        if (tick) begin
            if (sync != deb_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    deb_next = sync;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end else begin
                cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            deb_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            deb_reg <= deb_next;
        end
    end

    assign deb        = deb_reg;
    assign rise_pulse = accept & sync;
    assign fall_pulse = accept & ~sync;

endmodule

// File: rtl/chu_debounce_gpi.sv
// MMIO slot core: synchronised, debounced N-bit input with sticky W1C
// rise/fall flags, programmable sample prescaler and maskable level irq.
module chu_debounce_gpi
    import chu_gpi_pkg::*;
#(
    parameter int                 W          = 8,
    parameter int                 DB_SAMPLES = 4,
    parameter logic [PRESC_W-1:0] DEF_PERIOD = 16'd49999
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    input  logic [W-1:0] din,
    output logic         irq
);

    logic [W-1:0]       meta_reg, sync_reg;
    logic [W-1:0]       deb, rise_pulse, fall_pulse;
    logic [W-1:0]       rise_reg, rise_next, fall_reg, fall_next, mask_reg;
    logic [PRESC_W-1:0] presc_reg, pcnt_reg, pcnt_next;
    logic               irq_reg;
    logic               tick, wr_en;
    logic               unused_bits;

    assign unused_bits = &{1'b0, read, wr_data};
    assign wr_en       = cs & write;
    assign tick        = (pcnt_reg == presc_reg);

    // A P write restarts the prescaler so the new period starts cleanly.
    always_comb begin
        pcnt_next = tick ? '0 : pcnt_reg + 1'b1;
        if (wr_en && addr == REG_PRESC)
            pcnt_next = '0;
    end

    // Fresh edge pulses are ORed in after the clear, so a set beats a W1C.
    always_comb begin
        rise_next = rise_reg;
        fall_next = fall_reg;
        if (wr_en && addr == REG_RISE)
            rise_next = rise_reg & ~wr_data[W-1:0];
        if (wr_en && addr == REG_FALL)
            fall_next = fall_reg & ~wr_data[W-1:0];
        rise_next = rise_next | rise_pulse;
        fall_next = fall_next | fall_pulse;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg  <= '0;
            sync_reg  <= '0;
            rise_reg  <= '0;
            fall_reg  <= '0;
            mask_reg  <= '0;
            presc_reg <= DEF_PERIOD;
            pcnt_reg  <= '0;
            irq_reg   <= 1'b0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            rise_reg <= rise_next;
            fall_reg <= fall_next;
            pcnt_reg <= pcnt_next;
            irq_reg  <= |((rise_reg | fall_reg) & mask_reg);
            if (wr_en && addr == REG_MASK)
                mask_reg <= wr_data[W-1:0];
            if (wr_en && addr == REG_PRESC)
                presc_reg <= wr_data[PRESC_W-1:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_ch
            chu_debounce_ch #(.DB_SAMPLES(DB_SAMPLES)) u_ch (
                .clk        (clk),
                .rst        (rst),
                .sync       (sync_reg[gi]),
                .tick       (tick),
                .deb        (deb[gi]),
                .rise_pulse (rise_pulse[gi]),
                .fall_pulse (fall_pulse[gi])
            );
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_SYNC:  rd_data[W-1:0]       = sync_reg;
            REG_DEB:   rd_data[W-1:0]       = deb;
            REG_RISE:  rd_data[W-1:0]       = rise_reg;
            REG_FALL:  rd_data[W-1:0]       = fall_reg;
            REG_MASK:  rd_data[W-1:0]       = mask_reg;
            REG_PRESC: rd_data[PRESC_W-1:0] = presc_reg;
            default:   rd_data              = '0;
        endcase
    end

    assign irq = irq_reg;

endmodule

// File: tb/tb_chu_debounce_gpi.sv
// Directed bench for chu_debounce_gpi: reset readback table, latency,
// glitch rejection, prescaler, W1C/irq and async reset corner cases.
module tb_chu_debounce_gpi;

    logic        clk, rst, cs, read, write;
    logic [4:0]  addr;
    logic [31:0] wr_data, rd_data;
    logic [7:0]  din;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    int n;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[7];

    chu_debounce_gpi #(.W(8), .DB_SAMPLES(4), .DEF_PERIOD(16'd49999)) dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .din     (din),
        .irq     (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h want=0x%08h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%08h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        chk(name, rd_data, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        step();
        cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; wr_data = '0; din = '0;
        tbl[0] = '{5'd0, 32'd0};
        tbl[1] = '{5'd1, 32'd0};
        tbl[2] = '{5'd2, 32'd0};
        tbl[3] = '{5'd3, 32'd0};
        tbl[4] = '{5'd4, 32'd0};
        tbl[5] = '{5'd5, 32'd49999};
        tbl[6] = '{5'd9, 32'd0};

        // Reset readback while rst is held
        #3;
        for (int i = 0; i < 7; i++)
            rd_chk(tbl[i].a, tbl[i].exp, $sformatf("reset_rd_addr%0d", tbl[i].a));
        chk("reset_irq", 32'(irq), 32'd0);
        #14 rst = 1'b0;
        step();

        // Clean edge with P=0: deb and rise appear at the 6th edge
        wr(5'd5, 32'd0);
        din[0] = 1'b1;
        repeat (5) step();
        rd_chk(5'd1, 32'h00, "clean_deb_edge5");
        step();
        rd_chk(5'd1, 32'h01, "clean_deb_edge6");
        rd_chk(5'd2, 32'h01, "clean_rise_flag");
        chk("irq_masked", 32'(irq), 32'd0);

        // Mask then W1C
        wr(5'd4, 32'h01);
        chk("irq_not_yet", 32'(irq), 32'd0);
        step();
        chk("irq_set", 32'(irq), 32'd1);
        wr(5'd2, 32'h01);
        rd_chk(5'd2, 32'h00, "w1c_rise_clear");
        chk("irq_lag", 32'(irq), 32'd1);
        step();
        chk("irq_clear", 32'(irq), 32'd0);

        // Glitch of 3 cycles on din[3] must be rejected
        din[3] = 1'b1;
        repeat (3) step();
        din[3] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            rd_chk(5'd1, 32'h01, $sformatf("glitch_deb_c%0d", i));
            rd_chk(5'd2, 32'h00, $sformatf("glitch_rise_c%0d", i));
        end

        // Fall, then W1C coinciding with a new rise on bit 0
        din[0] = 1'b0;
        repeat (6) step();
        rd_chk(5'd3, 32'h01, "fall_set");
        din[0] = 1'b1;
        repeat (5) step();
        wr(5'd2, 32'h01);
        rd_chk(5'd2, 32'h01, "w1c_race_set_wins");
        rd_chk(5'd1, 32'h01, "race_deb");
        wr(5'd3, 32'h00);
        rd_chk(5'd3, 32'h01, "w1c_zero_keeps");
        wr(5'd3, 32'h01);
        rd_chk(5'd3, 32'h00, "w1c_fall_clear");
        wr(5'd2, 32'h01);
        rd_chk(5'd2, 32'h00, "w1c_rise_clear2");
        wr(5'd9, 32'hFF);
        rd_chk(5'd4, 32'h01, "unmapped_write_ignored");

        // Prescale P=9: deb[1] expected between 32 and 42 edges
        wr(5'd5, 32'd9);
        rd_chk(5'd5, 32'd9, "presc_readback");
        din[1] = 1'b1;
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            addr = 5'd1;
            #1;
            if (rd_data[1]) begin
                n = k;
                break;
            end
        end
        checks++;
        if (!(n >= 32 && n <= 42)) begin
            failures++;
            $display("FAIL presc_latency got=%0d edges want=32..42 (0 = timeout)", n);
        end else begin
            $display("ok   presc_latency = %0d edges", n);
        end

        // Large P stalls debounce; rewriting P=0 ticks from the next cycle
        wr(5'd5, 32'd1000);
        din[2] = 1'b1;
        repeat (4) step();
        rd_chk(5'd1, 32'h03, "presc_stall");
        wr(5'd5, 32'd0);
        repeat (3) step();
        rd_chk(5'd1, 32'h03, "presc_rewrite_edge3");
        step();
        rd_chk(5'd1, 32'h07, "presc_rewrite_edge4");

        // Async reset mid-debounce (cnt == 2 on din[4])
        din[4] = 1'b1;
        repeat (4) step();
        #2 rst = 1'b1;
        rd_chk(5'd0, 32'h00, "areset_sync");
        rd_chk(5'd1, 32'h00, "areset_deb");
        rd_chk(5'd2, 32'h00, "areset_rise");
        rd_chk(5'd4, 32'h00, "areset_mask");
        rd_chk(5'd5, 32'd49999, "areset_presc");
        chk("areset_irq", 32'(irq), 32'd0);
        din = '0;
        #3 rst = 1'b0;
        step();
        wr(5'd5, 32'd0);
        repeat (8) step();
        din = 8'h10;
        repeat (5) step();
        rd_chk(5'd1, 32'h00, "post_reset_edge5");
        step();
        rd_chk(5'd1, 32'h10, "post_reset_edge6");
        rd_chk(5'd2, 32'h10, "post_reset_rise");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
